// File: rtl/lut_ctrl_pkg.sv
// Shared state encoding and default sizing for the LUT access controller.
// No logic; constants and types only.
package lut_ctrl_pkg;

  typedef enum logic {
    ST_LOAD  = 1'b0,
    ST_READY = 1'b1
  } lut_state_t;

  localparam int DEF_QUAN_SIZE       = 3;
  localparam int DEF_PAGE_NUM        = 16;
  localparam int DEF_ADDR_BITWIDTH   = 4;
  localparam int DEF_REQ_NUM         = 4;
  localparam int DEF_REQ_ID_BITWIDTH = 2;

endpackage

// File: rtl/lut_rr_arbiter.sv
// Round-robin arbiter: search starts at ptr, returns one-hot grant and index.
// Purely combinational, zero latency; no backpressure (requesters hold req).
module lut_rr_arbiter
  import lut_ctrl_pkg::*;
#(
  parameter int REQ_NUM         = DEF_REQ_NUM,
  parameter int REQ_ID_BITWIDTH = DEF_REQ_ID_BITWIDTH
) (
  input  logic [REQ_NUM-1:0]         req,
  input  logic [REQ_ID_BITWIDTH-1:0] ptr,
  output logic [REQ_NUM-1:0]         gnt,
  output logic [REQ_ID_BITWIDTH-1:0] gnt_idx,
  output logic                       gnt_vld
);

  logic [REQ_ID_BITWIDTH-1:0] idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    idx     = '0;
    for (int i = 0; i < REQ_NUM; i++) begin
      idx = REQ_ID_BITWIDTH'((int'(ptr) + i) % REQ_NUM);
      if (!gnt_vld && req[idx]) begin
        gnt_vld  = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/lut_access_ctrl.sv
// LUT access controller: sequential table load, then round-robin read arbitration.
// Read latency 1 cycle (grant -> rd_valid_o); loads always accepted while loading.
// Optional table reload is enabled by defining LUT_ACCESS_CTRL_RELOAD_EN.
module lut_access_ctrl
  import lut_ctrl_pkg::*;
#(
  parameter int QUAN_SIZE       = DEF_QUAN_SIZE,
  parameter int PAGE_NUM        = DEF_PAGE_NUM,
  parameter int ADDR_BITWIDTH   = DEF_ADDR_BITWIDTH,
  parameter int REQ_NUM         = DEF_REQ_NUM,
  parameter int REQ_ID_BITWIDTH = DEF_REQ_ID_BITWIDTH
) (
  input  logic                             sys_clk,
  input  logic                             rstn,
  input  logic [QUAN_SIZE-1:0]             load_data_i,
  input  logic                             load_valid_i,
  output logic                             load_ready_o,
  input  logic                             reload_i,
  input  logic [REQ_NUM-1:0]               rd_req_i,
  input  logic [REQ_NUM*ADDR_BITWIDTH-1:0] rd_addr_i,
  output logic [REQ_NUM-1:0]               rd_gnt_o,
  output logic [QUAN_SIZE-1:0]             rd_data_o,
  output logic                             rd_valid_o,
  output logic [REQ_ID_BITWIDTH-1:0]       rd_id_o,
  output logic                             table_ready_o,
  output logic [ADDR_BITWIDTH-1:0]         mem_addr_o,
  output logic                             mem_we_o,
  output logic [QUAN_SIZE-1:0]             mem_wdata_o,
  input  logic [QUAN_SIZE-1:0]             mem_rdata_i
);

  lut_state_t                 state_q, state_d;
  logic [ADDR_BITWIDTH-1:0]   load_cnt_q, load_cnt_d;
  logic [REQ_ID_BITWIDTH-1:0] ptr_q, ptr_d;
  logic [REQ_NUM-1:0]         arb_gnt;
  logic [REQ_ID_BITWIDTH-1:0] arb_idx;
  logic                       arb_vld;
  logic                       reload_act;
  logic                       rd_fire;

`ifdef LUT_ACCESS_CTRL_RELOAD_EN
  assign reload_act = reload_i;
`else
  logic unused_reload;
  assign unused_reload = reload_i;
  assign reload_act    = 1'b0;
`endif

  lut_rr_arbiter #(
    .REQ_NUM        (REQ_NUM),
    .REQ_ID_BITWIDTH(REQ_ID_BITWIDTH)
  ) u_arb (
    .req    (rd_req_i),
    .ptr    (ptr_q),
    .gnt    (arb_gnt),
    .gnt_idx(arb_idx),
    .gnt_vld(arb_vld)
  );

  always_comb begin
    state_d      = state_q;
    load_cnt_d   = load_cnt_q;
    ptr_d        = ptr_q;
    load_ready_o = 1'b0;
    mem_we_o     = 1'b0;
    mem_wdata_o  = load_data_i;
    mem_addr_o   = '0;
    rd_gnt_o     = '0;
    rd_fire      = 1'b0;
    case (state_q)
      ST_LOAD: begin
        load_ready_o = 1'b1;
        mem_addr_o   = load_cnt_q;
        if (load_valid_i) begin
          mem_we_o = 1'b1;
          if (load_cnt_q == ADDR_BITWIDTH'(PAGE_NUM - 1)) begin
            load_cnt_d = '0;
            state_d    = ST_READY;
          end else begin
            load_cnt_d = load_cnt_q + 1'b1;
          end
        end
      end
      ST_READY: begin
        // Reload wins over any pending read in the same cycle.
        if (reload_act) begin
          state_d    = ST_LOAD;
          load_cnt_d = '0;
        end else if (arb_vld) begin
          rd_fire  = 1'b1;
          rd_gnt_o = arb_gnt;
          for (int k = 0; k < REQ_NUM; k++) begin
            if (arb_idx == REQ_ID_BITWIDTH'(k)) begin
              mem_addr_o = rd_addr_i[k*ADDR_BITWIDTH +: ADDR_BITWIDTH];
            end
          end
          ptr_d = (arb_idx == REQ_ID_BITWIDTH'(REQ_NUM - 1)) ? '0 : arb_idx + 1'b1;
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= ST_LOAD;
      load_cnt_q    <= '0;
      ptr_q         <= '0;
      table_ready_o <= 1'b0;
      rd_valid_o    <= 1'b0;
      rd_id_o       <= '0;
    end else begin
      state_q       <= state_d;
      load_cnt_q    <= load_cnt_d;
      ptr_q         <= ptr_d;
      table_ready_o <= (state_d == ST_READY);
      rd_valid_o    <= rd_fire;
      if (rd_fire) begin
        rd_id_o <= arb_idx;
      end
    end
  end

  // Memory read port is already registered, so data aligns with rd_valid_o.
  assign rd_data_o = mem_rdata_i;

endmodule
